// File: rtl/spike_address_if.sv
// Spike-address bus bundle.
// Groups the timestep handshake from the neuron layer (ts_valid/ts_ready/spike_vec)
// with the address bus and status outputs that fan out to the MAC units.
//   master : neuron-layer side, drives ts_valid and spike_vec, observes everything else
//   slave  : spike_address_tx side, accepts timesteps and drives the address bus
interface spike_address_if #(
  parameter int NUM_NEURONS = 30,
  parameter int ADDR_W      = 12,
  parameter int CNT_W       = 6
) ();
  logic                   ts_valid;
  logic                   ts_ready;
  logic [NUM_NEURONS-1:0] spike_vec;
  logic [ADDR_W-1:0]      source_address;
  logic                   addr_valid;
  logic                   clear_out;
  logic                   done;
  logic [CNT_W-1:0]       spike_count;

  modport master (
    output ts_valid, spike_vec,
    input  ts_ready, source_address, addr_valid, clear_out, done, spike_count
  );

  modport slave (
    input  ts_valid, spike_vec,
    output ts_ready, source_address, addr_valid, clear_out, done, spike_count
  );
endinterface

// File: rtl/spike_address_tx.sv
// Spike-address transmitter.
// Accepts one timestep's fired-neuron vector, sends BASE_ADDR+i for every set bit i
// (lowest index first, each held ADDR_HOLD cycles and followed by one idle cycle),
// then raises clear_out for CLEAR_CYCLES cycles and pulses done with spike_count.
// Ports:
//   clock  in  single clock, posedge
//   rst_n  in  asynchronous active-low reset
//   bus    spike_address_if.slave: ts_valid/ts_ready/spike_vec in, source_address,
//          addr_valid, clear_out, done, spike_count out (all outputs registered)
//
// state | meaning
// IDLE  | ts_ready high, waiting for a timestep; done pulses on the first IDLE cycle
// SEND  | source_address = BASE_ADDR+idx, addr_valid high, ADDR_HOLD cycles
// GAP   | one idle-address cycle between spikes so the MACs see an edge
// CLEAR | clear_out high for CLEAR_CYCLES cycles
module spike_address_tx #(
  parameter int                NUM_NEURONS  = 30,
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'd0,
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = 12'hFFF,
  parameter int                ADDR_HOLD    = 1,
  parameter int                CLEAR_CYCLES = 2,
  parameter int                CNT_W        = 6
) (
  input logic           clock,
  input logic           rst_n,
  spike_address_if.slave bus
);

  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int HOLD_W = $clog2(ADDR_HOLD) + 1;
  localparam int CLR_W  = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ADDR_HOLD - 1);
  localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, CLEAR} state_t;

  state_t                 state, state_nx;
  logic [NUM_NEURONS-1:0] pending, pending_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [HOLD_W-1:0]      hold_cnt, hold_nx;
  logic [CLR_W-1:0]       clr_cnt, clr_nx;
  logic [CNT_W-1:0]       count, count_nx;

  logic [ADDR_W-1:0]      addr_q, addr_nx;
  logic                   valid_q, valid_nx;
  logic                   clear_q, clear_nx;
  logic                   done_q, done_nx;
  logic                   ready_q, ready_nx;
  logic [CNT_W-1:0]       spike_count_q, spike_count_nx;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      idx           <= '0;
      hold_cnt      <= '0;
      clr_cnt       <= '0;
      count         <= '0;
      addr_q        <= IDLE_ADDR;
      valid_q       <= 1'b0;
      clear_q       <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
      spike_count_q <= '0;
    end else begin
      state         <= state_nx;
      pending       <= pending_nx;
      idx           <= idx_nx;
      hold_cnt      <= hold_nx;
      clr_cnt       <= clr_nx;
      count         <= count_nx;
      addr_q        <= addr_nx;
      valid_q       <= valid_nx;
      clear_q       <= clear_nx;
      done_q        <= done_nx;
      ready_q       <= ready_nx;
      spike_count_q <= spike_count_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pending_nx     = pending;
    idx_nx         = idx;
    hold_nx        = hold_cnt;
    clr_nx         = clr_cnt;
    count_nx       = count;
    done_nx        = 1'b0;
    spike_count_nx = spike_count_q;

    case (state)
      IDLE: begin
        if (bus.ts_valid) begin
          pending_nx = bus.spike_vec;
          count_nx   = '0;
          if (bus.spike_vec != '0) begin
            state_nx = SEND;
            idx_nx   = lowest_set(bus.spike_vec);
            hold_nx  = HOLD_LOAD;
          end else begin
            state_nx = CLEAR;
            clr_nx   = CLR_LOAD;
          end
        end
      end
      SEND: begin
        if (hold_cnt == '0) begin
          pending_nx[idx] = 1'b0;
          count_nx        = count + CNT_W'(1);
          state_nx        = GAP;
        end else begin
          hold_nx = hold_cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        if (pending != '0) begin
          state_nx = SEND;
          idx_nx   = lowest_set(pending);
          hold_nx  = HOLD_LOAD;
        end else begin
          state_nx = CLEAR;
          clr_nx   = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (clr_cnt == '0) begin
          state_nx       = IDLE;
          done_nx        = 1'b1;
          spike_count_nx = count;
        end else begin
          clr_nx = clr_cnt - CLR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are computed from the next state and registered, so the bus
    // reflects the state it will be in for the whole coming cycle.
    addr_nx  = (state_nx == SEND) ? (BASE_ADDR + ADDR_W'(idx_nx)) : IDLE_ADDR;
    valid_nx = (state_nx == SEND);
    clear_nx = (state_nx == CLEAR);
    ready_nx = (state_nx == IDLE);
  end

  assign bus.source_address = addr_q;
  assign bus.addr_valid     = valid_q;
  assign bus.clear_out      = clear_q;
  assign bus.done           = done_q;
  assign bus.ts_ready       = ready_q;
  assign bus.spike_count    = spike_count_q;

endmodule
